// File: rtl/unlock_code_tx.sv
// unlock_code_tx: shifts a parallel unlock code MSB-first into the safe lock as single-cycle strobes and reports the lock's verdict.
// Ports: clk, rstn (async active-low); code_val/code_data/code_rdy host handshake; ser_val/ser_data registered strobes to the lock;
//   resp_val/resp_data lock Moore response; busy/done status; unlocked/resp_err result held until the next accept.
// Build option: define UNLOCK_TX_FLUSH_EN to add a trailing ser_data=0 strobe that returns the lock to its idle state.
module unlock_code_tx #(
  parameter int CODE_W = 4,
  parameter int GAP    = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              code_val,
  input  logic [CODE_W-1:0] code_data,
  output logic              code_rdy,
  output logic              ser_val,
  output logic              ser_data,
  input  logic              resp_val,
  input  logic              resp_data,
  output logic              busy,
  output logic              done,
  output logic              unlocked,
  output logic              resp_err
);
  localparam int BW = $clog2(CODE_W + 1);
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CODE_W - 1);
  localparam logic [GW-1:0] GAP_LD = GW'((GAP > 0) ? GAP - 1 : 0);
  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_WAIT,
`ifdef UNLOCK_TX_FLUSH_EN
    S_FLUSH,
`endif
    S_DONE
  } state_t;
  state_t state_q, state_d;
  logic [CODE_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic ser_val_q, ser_val_d, ser_data_q, ser_data_d;
  logic busy_q, busy_d, done_q, done_d;
  logic unlocked_q, unlocked_d, resp_err_q, resp_err_d;
  // Outputs are registered from the next state, so a strobe appears in the very cycle the FSM sits in SHIFT/FLUSH.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    unlocked_d = unlocked_q;
    resp_err_d = resp_err_q;
    unique case (state_q)
      S_IDLE: if (code_val) begin
        state_d    = S_SHIFT;
        shreg_d    = code_data;
        bit_cnt_d  = '0;
        unlocked_d = 1'b0;
        resp_err_d = 1'b0;
      end
      S_SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        gap_cnt_d = GAP_LD;
        state_d   = (bit_cnt_q == LAST_BIT) ? S_WAIT : (GAP == 0) ? S_SHIFT : S_GAP;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        state_d   = (gap_cnt_q == '0) ? S_SHIFT : S_GAP;
      end
      S_WAIT: begin
        // The lock's Moore output reflects the last bit one cycle after its strobe, i.e. now.
        unlocked_d = resp_val & resp_data;
        resp_err_d = !resp_val;
`ifdef UNLOCK_TX_FLUSH_EN
        state_d    = S_FLUSH;
`else
        state_d    = S_DONE;
`endif
      end
`ifdef UNLOCK_TX_FLUSH_EN
      S_FLUSH: state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef UNLOCK_TX_FLUSH_EN
    ser_val_d  = (state_d == S_SHIFT) | (state_d == S_FLUSH);
`else
    ser_val_d  = state_d == S_SHIFT;
`endif
    ser_data_d = (state_d == S_SHIFT) & shreg_d[CODE_W-1];
    busy_d     = state_d != S_IDLE;
    done_d     = state_d == S_DONE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      ser_val_q  <= 1'b0;
      ser_data_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      unlocked_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ser_val_q  <= ser_val_d;
      ser_data_q <= ser_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      unlocked_q <= unlocked_d;
      resp_err_q <= resp_err_d;
    end
  end
  assign code_rdy = state_q == S_IDLE;
  assign ser_val  = ser_val_q;
  assign ser_data = ser_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign unlocked = unlocked_q;
  assign resp_err = resp_err_q;
endmodule

// File: doc/unlock_code_tx.md
# unlock_code_tx

Serial code transmitter that drives the safe-lock serial input. It accepts a parallel code word through a valid/ready handshake and shifts it out MSB-first as single-cycle `ser_val`/`ser_data` strobes, with a configurable number of idle cycles between bits. It then samples the lock's Moore response (`output_val`/`output_data`) and reports the unlock result to the keypad/host controller.

## Interface
- `CODE_W`, default 4: code length in bits; legal range ≥1.
- `GAP`, default 0: idle cycles (`ser_val`=0) inserted between consecutive bit strobes; legal range ≥0.

- `clk`  in  1  single clock; all logic on posedge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `code_val`  in  1  host offers `code_data`.
- `code_data`  in  CODE_W  code word; bit CODE_W-1 is sent first.
- `code_rdy`  out  1  block can accept a code; high only in IDLE.
- `ser_val`  out  1  serial bit strobe to the lock, registered.
- `ser_data`  out  1  serial bit value, registered; 0 whenever `ser_val`=0.
- `resp_val`  in  1  lock `output_val`.
- `resp_data`  in  1  lock `output_data`.
- `busy`  out  1  transfer in progress, from the cycle after accept through the DONE cycle.
- `done`  out  1  one-cycle result pulse.
- `unlocked`  out  1  result: `resp_val & resp_data` at sample time; held until the next accept.
- `resp_err`  out  1  `!resp_val` at sample time; held until the next accept.

## Operation
- States: IDLE, SHIFT, GAP, WAIT, FLUSH (only with the macro), DONE.
- IDLE: `code_rdy`=1. `code_val`=1 latches `code_data` into the shift register, clears `bit_cnt`, clears `unlocked`/`resp_err`, and moves to SHIFT.
- SHIFT: drives `ser_val`=1 and `ser_data`=shreg MSB for exactly one cycle, shifts left, and increments `bit_cnt`. If this was the last bit, go to WAIT. Otherwise go to GAP, or stay in SHIFT when GAP=0.
- GAP: `ser_val`=0 for exactly GAP cycles (`gap_cnt` counts down from GAP-1), then SHIFT.
- WAIT: one cycle with `ser_val`=0. At its end, capture `unlocked`=`resp_val&resp_data` and `resp_err`=`!resp_val`.
- FLUSH: one cycle with `ser_val`=1, `ser_data`=0, which returns the lock from its post-code state toward IDLE. Then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Counter widths: `bit_cnt` is $clog2(CODE_W+1); `gap_cnt` is max(1,$clog2(GAP+1)). No wrap beyond CODE_W.
- `code_val` outside IDLE is ignored. `code_data` is not required stable after accept.
- Reset, asynchronous including mid-transfer: state→IDLE; `ser_val`, `ser_data`, `busy`, `done`, `unlocked`, `resp_err`, shift register and counters→0. `code_rdy`=1 while in IDLE, including during reset. A partial code is discarded and nothing is resumed.

## Timing
- Cycle 0 is the accept edge (`code_val`&`code_rdy` sampled high).
- Bit i (i=0..CODE_W-1) is strobed in cycle 1+i·(GAP+1). Last bit is at L=1+(CODE_W-1)(GAP+1).
- WAIT is cycle L+1. The response is sampled at the end of L+1 because the lock's Moore output reflects bit L one cycle later.
- Without flush: DONE at L+2. With flush: FLUSH at L+2 and DONE at L+3.
- `code_rdy` is low from cycle 1 through DONE and returns high the cycle after DONE.
- Throughput: one code per CODE_W+(CODE_W-1)·GAP+3 cycles (+1 with flush).

## Configuration
- `UNLOCK_TX_FLUSH_EN` defined: the FLUSH state is compiled in, and one extra strobe with `ser_data`=0 is sent after sampling, so back-to-back codes start from lock IDLE.
- Not defined: there is no FLUSH state, and WAIT goes directly to DONE. The host is then responsible for resynchronising the lock, for example via `rstn`.

## Test plan
- CODE_W=4, GAP=0, `unlock_mech_moore` in loop, code 4'b1011 → strobes in cycles 1–4 with data 1,0,1,1; `done` in cycle 6; `unlocked`=1, `resp_err`=0.
- Same setup, code 4'b1001 → lock reaches INCORRECT; `done` in cycle 6; `unlocked`=0.
- GAP=2, code 4'b1011 → strobes in cycles 1,4,7,10 only; `ser_val`=0 in between; `done` in cycle 12; `unlocked`=1.
- Flush enabled, code 4'b1011 then immediately 4'b1011 → extra strobe (`ser_data`=0) in cycle 6, `done` in cycle 7; second code also gives `unlocked`=1.
- `resp_val` forced 0, any code → `done` with `unlocked`=0 and `resp_err`=1. `code_val` pulsed while `busy` → ignored, no extra strobes.
- `rstn` low in cycle 3 of a transfer → all outputs 0 asynchronously and `code_rdy`=1. After release, a new code 4'b1011 completes normally.
